// File: rtl/tick_pkg.sv
// Shared constants for the tick divider: default counter width, default divisor
// and the smallest divisor a load may request.
package tick_pkg;

  localparam int TICK_DEFAULT_WIDTH = 16;
  localparam int TICK_DEFAULT_DIV   = 50000;
  localparam int TICK_MIN_DIV       = 2;

endpackage

// File: rtl/tick_div_shadow.sv
// Divisor management for tick_divider: active/shadow divisors, the pending flag
// and the sticky error raised by a rejected load.
module tick_div_shadow
  import tick_pkg::*;
#(
  parameter int WIDTH       = TICK_DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = TICK_DEFAULT_DIV
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wrap,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic [WIDTH-1:0] act,
  output logic             pending,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] MIN_DIV_C   = WIDTH'(TICK_MIN_DIV);
  localparam logic [WIDTH-1:0] RESET_DIV_C = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] act_r;
  logic [WIDTH-1:0] shd_r;
  logic             pending_r;
  logic             err_r;
  logic             accept_s;
  logic             reject_s;

  // Classify a load request; requests arriving while one is pending are dropped.
  always_comb begin
    accept_s = 1'b0;
    reject_s = 1'b0;
    if (div_load && !pending_r) begin
      if (div_in >= MIN_DIV_C) begin
        accept_s = 1'b1;
      end else begin
        reject_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      reject_s = 1'b0;
    end
  end

  // Divisor state: clear commits a pending or simultaneous load at once,
  // otherwise a pending divisor waits for the wrap so the running period finishes.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      act_r     <= RESET_DIV_C;
      shd_r     <= RESET_DIV_C;
      pending_r <= 1'b0;
      err_r     <= 1'b0;
    end else if (clear) begin
      err_r     <= 1'b0;
      pending_r <= 1'b0;
      if (pending_r) begin
        act_r <= shd_r;
      end else if (accept_s) begin
        act_r <= div_in;
      end else begin
        act_r <= act_r;
      end
    end else begin
      if (accept_s) begin
        shd_r     <= div_in;
        pending_r <= 1'b1;
      end else if (wrap && pending_r) begin
        act_r     <= shd_r;
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
      if (reject_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign act     = act_r;
  assign pending = pending_r;
  assign div_err = err_r;

endmodule

// File: rtl/tick_divider.sv
// Programmable tick divider: one registered tick every N enabled clocks.
// Optional square-wave output is built only when TICK_DIVIDER_SQUARE_EN is defined.
module tick_divider
  import tick_pkg::*;
#(
  parameter int WIDTH       = TICK_DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = TICK_DEFAULT_DIV
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ready,
  output logic             div_err,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             sq_out
);

  logic [WIDTH-1:0] count_r;
  logic             tick_r;
  logic [WIDTH-1:0] act_s;
  logic [WIDTH-1:0] last_s;
  logic             pending_s;
  logic             wrap_s;

  tick_div_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_shadow (
    .clock    (clock),
    .rst_n    (rst_n),
    .clear    (clear),
    .wrap     (wrap_s),
    .div_load (div_load),
    .div_in   (div_in),
    .act      (act_s),
    .pending  (pending_s),
    .div_err  (div_err)
  );

  assign last_s = act_s - WIDTH'(1);

  // A wrap is the enabled edge that ends the current period; clear pre-empts it.
  always_comb begin
    wrap_s = 1'b0;
    if (enable && !clear && (count_r == last_s)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Phase counter and tick pulse.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else if (clear) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else if (wrap_s) begin
      count_r <= '0;
      tick_r  <= 1'b1;
    end else if (enable) begin
      count_r <= count_r + WIDTH'(1);
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_r;
      tick_r  <= 1'b0;
    end
  end

`ifdef TICK_DIVIDER_SQUARE_EN
  logic sq_r;

  // Square wave flips on every wrap, giving period 2N at 50% duty.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sq_r <= 1'b0;
    end else if (clear) begin
      sq_r <= 1'b0;
    end else if (wrap_s) begin
      sq_r <= ~sq_r;
    end else begin
      sq_r <= sq_r;
    end
  end

  assign sq_out = sq_r;
`else
  assign sq_out = 1'b0;
`endif

  assign tick      = tick_r;
  assign count     = count_r;
  assign div_ready = ~pending_s;

endmodule
